cache_arbiter: RTL and testbench

Arbitrates the single line-granular memory port between the instruction cache and the data cache of the mp4 core. It sits between the two cache miss/writeback interfaces and the cacheline adaptor that drives the burst memory. It serves one full-line transaction at a time, resolves simultaneous misses round-robin (or with fixed data priority), and exposes free-running arbitration statistics for performance runs.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_perf_counters.sv | 34 +++
 rtl/cache_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default widths for the cache/memory arbitration slice.
package arb_pkg;

  // Default widths shared with the caches and the cacheline adaptor.
  localparam int unsigned DEFAULT_LINE_W = 256;
  localparam int unsigned DEFAULT_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Free-running arbitration statistics: grants per requester and IDLE tie cycles.
module arb_perf_counters import arb_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_grant_inc,
  input  logic        d_grant_inc,
  input  logic        conflict_inc,
  output logic [31:0] i_grants,
  output logic [31:0] d_grants,
  output logic [31:0] conflicts
);

  logic [31:0] i_grants_q;
  logic [31:0] d_grants_q;
  logic [31:0] conflicts_q;

  // Wrapping counters; 32-bit overflow gives 0xFFFF_FFFF -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grants_q  <= '0;
      d_grants_q  <= '0;
      conflicts_q <= '0;
    end else begin
      if (i_grant_inc)  i_grants_q  <= i_grants_q + 32'd1;
      if (d_grant_inc)  d_grants_q  <= d_grants_q + 32'd1;
      if (conflict_inc) conflicts_q <= conflicts_q + 32'd1;
    end
  end

  assign i_grants  = i_grants_q;
  assign d_grants  = d_grants_q;
  assign conflicts = conflicts_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single line-granular memory port between icache and dcache.
// One full-line transaction in flight at a time; ties resolved round-robin or
// with fixed dcache priority.
module cache_arbiter import arb_pkg::*; #(
  parameter int unsigned LINE_W          = DEFAULT_LINE_W,
  parameter int unsigned ADDR_W          = DEFAULT_ADDR_W,
  parameter bit          DCACHE_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  // Icache side
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  // Dcache side
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  // Adaptor side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  // Statistics
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants,
  output logic [31:0]       conflicts
);

  arb_state_t  state_q, state_d;
  requester_t  last_grant_q, last_grant_d;
  logic        i_req, d_req;
  logic        grant_i, grant_d, conflict;

  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // Next-state and grant decision; requests are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    conflict     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          conflict = 1'b1;
          if (DCACHE_PRIORITY || (last_grant_q == REQ_I)) grant_d = 1'b1;
          else                                            grant_i = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = REQ_I;
        end
        if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = REQ_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and capture of the winner's request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_D;  // icache wins the first tie
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (grant_i) begin
        mem_read_q    <= 1'b1;
        mem_write_q   <= 1'b0;
        mem_address_q <= i_mem_address;
      end else if (grant_d) begin
        // Write wins if the dcache illegally raises both.
        mem_read_q    <= ~d_mem_write;
        mem_write_q   <= d_mem_write;
        mem_address_q <= d_mem_address;
        mem_wdata_q   <= d_mem_wdata;
      end else if ((state_q != IDLE) && mem_resp) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // Completion is steered combinationally to the owner only.
  assign i_mem_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_mem_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  arb_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_grant_inc  (grant_i),
    .d_grant_inc  (grant_d),
    .conflict_inc (conflict),
    .i_grants     (i_grants),
    .d_grants     (d_grants),
    .conflicts    (conflicts)
  );

  // Read and write together from the dcache is an encoding error.
  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(d_mem_read && d_mem_write))
    else $error("cache_arbiter: d_mem_read and d_mem_write both high");

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_cache_arbiter;
  import arb_pkg::*;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;
  typedef logic [LW-1:0] line_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read, d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata, d_mem_rdata;
  logic          d_mem_resp;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp;
  logic [31:0]   i_grants, d_grants, conflicts;

  // Second instance with fixed dcache priority, sharing all inputs.
  logic [LW-1:0] p_i_mem_rdata, p_d_mem_rdata, p_mem_wdata;
  logic          p_i_mem_resp, p_d_mem_resp, p_mem_read, p_mem_write;
  logic [AW-1:0] p_mem_address;
  logic [31:0]   p_i_grants, p_d_grants, p_conflicts;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .DCACHE_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_grants(i_grants), .d_grants(d_grants), .conflicts(conflicts)
  );

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .DCACHE_PRIORITY(1'b1)) dut_prio (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(p_i_mem_rdata), .i_mem_resp(p_i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(p_d_mem_rdata), .d_mem_resp(p_d_mem_resp),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_address(p_mem_address),
    .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .i_grants(p_i_grants), .d_grants(p_d_grants), .conflicts(p_conflicts)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic line_t rand_line();
    line_t v;
    for (int k = 0; k < int'(LW / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return $urandom & 32'hFFFF_FFE0;
  endfunction

  task automatic clear_inputs();
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    mem_rdata     = '0;
    mem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  line_t         wd, rd;
  logic [AW-1:0] exp_addr;

  // Reference model state (transaction level).
  bit            busy, own_d, own_wr, last_was_i, i_done, d_done, ir, dr, take_d;
  logic [AW-1:0] own_addr;
  line_t         own_wdata;
  int unsigned   m_i, m_d, m_c;
  int            ad_wait;
  bit            exp_ir, exp_dr;

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset state
    do_reset();
    #1;
    check("rst_mem_read",  line_t'(mem_read),    line_t'(1'b0));
    check("rst_mem_write", line_t'(mem_write),   line_t'(1'b0));
    check("rst_mem_addr",  line_t'(mem_address), line_t'(0));
    check("rst_mem_wdata", mem_wdata,            line_t'(0));
    check("rst_counters",  line_t'({i_grants, d_grants, conflicts}), line_t'(0));

    // Icache-only read of 0x60, adaptor answers on the 4th op cycle
    i_mem_read = 1'b1; i_mem_address = 32'h60;
    #1 check("i_only_no_early_read", line_t'(mem_read), line_t'(1'b0));
    @(negedge clk); #1;
    check("i_only_read_rise", line_t'(mem_read),    line_t'(1'b1));
    check("i_only_addr",      line_t'(mem_address), line_t'(32'h60));
    for (int k = 0; k < 3; k++) @(negedge clk);
    rd = {32{8'hAB}};
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    check("i_only_resp",    line_t'(i_mem_resp), line_t'(1'b1));
    check("i_only_rdata",   i_mem_rdata,         rd);
    check("i_only_d_resp",  line_t'(d_mem_resp), line_t'(1'b0));
    check("i_only_igrants", line_t'(i_grants),   line_t'(1));
    @(negedge clk);
    clear_inputs();
    #1 check("i_only_read_fall", line_t'(mem_read), line_t'(1'b0));

    // Simultaneous i-read 0x100 / d-write 0x200: icache first, then dcache
    do_reset();
    wd = rand_line();
    i_mem_read = 1'b1; i_mem_address = 32'h100;
    d_mem_write = 1'b1; d_mem_address = 32'h200; d_mem_wdata = wd;
    @(negedge clk); #1;
    check("tie_first_read", line_t'(mem_read),    line_t'(1'b1));
    check("tie_first_addr", line_t'(mem_address), line_t'(32'h100));
    check("tie_conflicts",  line_t'(conflicts),   line_t'(1));
    mem_resp = 1'b1;
    #1 check("tie_i_resp", line_t'({i_mem_resp, d_mem_resp}), line_t'(2'b10));
    @(negedge clk);
    mem_resp = 1'b0; i_mem_read = 1'b0;
    #1 check("tie_idle_gap", line_t'({mem_read, mem_write}), line_t'(2'b00));
    @(negedge clk); #1;
    check("tie_d_write", line_t'(mem_write),   line_t'(1'b1));
    check("tie_d_addr",  line_t'(mem_address), line_t'(32'h200));
    check("tie_d_wdata", mem_wdata,            wd);
    d_mem_address = 32'hDEAD_BEE0;
    @(negedge clk); #1;
    check("addr_held_midtxn", line_t'(mem_address), line_t'(32'h200));
    rd = rand_line();
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    check("tie_d_resp",  line_t'({i_mem_resp, d_mem_resp}), line_t'(2'b01));
    check("tie_d_rdata", d_mem_rdata, rd);
    check("tie_conflicts_end", line_t'(conflicts), line_t'(1));
    @(negedge clk);
    clear_inputs();

    // Three back-to-back ties: round-robin I,D,I vs dcache priority D,D,D
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 32'h100;
    d_mem_read = 1'b1; d_mem_address = 32'h200;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); #1;
      exp_addr = (t == 1) ? 32'h200 : 32'h100;
      check($sformatf("rr_grant%0d", t),   line_t'(mem_address),   line_t'(exp_addr));
      check($sformatf("prio_grant%0d", t), line_t'(p_mem_address), line_t'(32'h200));
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
    end
    clear_inputs();
    #1;
    check("rr_conflicts",   line_t'(conflicts),   line_t'(3));
    check("rr_grants",      line_t'({i_grants, d_grants}),     line_t'({32'd2, 32'd1}));
    check("prio_conflicts", line_t'(p_conflicts), line_t'(3));
    check("prio_grants",    line_t'({p_i_grants, p_d_grants}), line_t'({32'd0, 32'd3}));

    // Asynchronous reset in the middle of a dcache write
    do_reset();
    d_mem_write = 1'b1; d_mem_address = 32'h300; d_mem_wdata = rand_line();
    @(negedge clk); #1;
    check("midrst_pre_write", line_t'(mem_write), line_t'(1'b1));
    mem_resp = 1'b1;
    #1 check("midrst_pre_resp", line_t'(d_mem_resp), line_t'(1'b1));
    #1 rst = 1'b1;
    #1;
    check("midrst_write_low", line_t'(mem_write),   line_t'(1'b0));
    check("midrst_resp_low",  line_t'(d_mem_resp),  line_t'(1'b0));
    check("midrst_addr_zero", line_t'(mem_address), line_t'(0));
    check("midrst_counters",  line_t'({i_grants, d_grants, conflicts}), line_t'(0));
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 32'h400;
    @(negedge clk); #1;
    check("postrst_read", line_t'(mem_read),    line_t'(1'b1));
    check("postrst_addr", line_t'(mem_address), line_t'(32'h400));
    check("postrst_igr",  line_t'(i_grants),    line_t'(1));
    mem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();

    // Stray mem_resp while idle is ignored
    @(negedge clk);
    mem_resp = 1'b1;
    #1 check("stray_resp", line_t'({i_mem_resp, d_mem_resp}), line_t'(2'b00));
    @(negedge clk);
    mem_resp = 1'b0;
    #1 check("stray_no_op", line_t'({mem_read, mem_write}), line_t'(2'b00));

    // Grant counter wrap
    do_reset();
    force dut.u_perf.d_grants_q = 32'hFFFF_FFFF;
    #1 release dut.u_perf.d_grants_q;
    d_mem_read = 1'b1; d_mem_address = 32'h80;
    @(negedge clk); #1;
    check("dgrant_wrap", line_t'(d_grants), line_t'(0));
    mem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();

    // Randomized traffic against the transaction-level model
    do_reset();
    busy = 1'b0; last_was_i = 1'b0; i_done = 1'b0; d_done = 1'b0;
    m_i = 0; m_d = 0; m_c = 0; ad_wait = -1;
    own_addr = '0; own_wdata = '0; own_d = 1'b0; own_wr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // Adaptor: answer an op after 0..4 extra cycles, sometimes glitch when idle.
      mem_resp = 1'b0;
      if (mem_read || mem_write) begin
        if (ad_wait < 0) ad_wait = int'($urandom_range(0, 4));
        if (ad_wait == 0) begin
          mem_resp = 1'b1; mem_rdata = rand_line(); ad_wait = -1;
        end else begin
          ad_wait--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        mem_resp = 1'b1; mem_rdata = rand_line();
      end
      // Icache agent
      if (i_done) begin
        i_mem_read = 1'b0; i_done = 1'b0;
      end else if (!i_mem_read) begin
        if ($urandom_range(0, 2) == 0) begin
          i_mem_read = 1'b1; i_mem_address = rand_addr();
        end
      end else if ($urandom_range(0, 7) == 0) begin
        i_mem_address = rand_addr();
      end
      // Dcache agent
      if (d_done) begin
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_done = 1'b0;
      end else if (!(d_mem_read || d_mem_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) d_mem_write = 1'b1;
          else                           d_mem_read  = 1'b1;
          d_mem_address = rand_addr(); d_mem_wdata = rand_line();
        end
      end else if ($urandom_range(0, 7) == 0) begin
        d_mem_address = rand_addr(); d_mem_wdata = rand_line();
      end
      #1;
      exp_ir = busy && !own_d && mem_resp;
      exp_dr = busy && own_d && mem_resp;
      check("rnd_mem_read",  line_t'(mem_read),  line_t'(busy && !own_wr));
      check("rnd_mem_write", line_t'(mem_write), line_t'(busy && own_wr));
      if (busy) check("rnd_mem_addr", line_t'(mem_address), line_t'(own_addr));
      if (busy && own_wr) check("rnd_mem_wdata", mem_wdata, own_wdata);
      check("rnd_resp", line_t'({i_mem_resp, d_mem_resp}), line_t'({exp_ir, exp_dr}));
      if (exp_ir) check("rnd_i_rdata", i_mem_rdata, mem_rdata);
      if (exp_dr) check("rnd_d_rdata", d_mem_rdata, mem_rdata);
      check("rnd_counters", line_t'({i_grants, d_grants, conflicts}),
            line_t'({m_i, m_d, m_c}));
      i_done = exp_ir;
      d_done = exp_dr;
      // Model: what the coming clock edge does.
      if (busy) begin
        if (mem_resp) busy = 1'b0;
      end else begin
        ir = i_mem_read;
        dr = d_mem_read || d_mem_write;
        if (ir || dr) begin
          take_d = dr && (!ir || last_was_i);
          if (ir && dr) m_c++;
          busy       = 1'b1;
          own_d      = take_d;
          own_wr     = take_d && d_mem_write;
          own_addr   = take_d ? d_mem_address : i_mem_address;
          if (own_wr) own_wdata = d_mem_wdata;
          last_was_i = !take_d;
          if (take_d) m_d++;
          else        m_i++;
        end
      end
    end
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
